mem_access_unit: RTL

- Load/store front-end for the byte-addressed, big-endian 32-bit data RAM; the pipeline MEM stage issues one request at a time.
- Drives the RAM's Address, writeData, Read and Write pins and captures its combinational read data.
- Adds byte, halfword and word access, with sign/zero extension on loads.
- Implements sub-word stores as read-modify-write, and flags misaligned or out-of-range accesses without touching RAM.

---
 rtl/mem_access_unit.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end for a byte-addressed, big-endian 32-bit data RAM.
// The RAM bus is documented with [32:1] numbering; here buses are [31:0], so byte offset 0
// occupies [31:24] and offset 3 occupies [7:0]. Sub-word stores are read-modify-write.
// The word buffer holds the word to be written and drives ram_writeData directly; it is
// zero whenever no write is in progress.
module mem_access_unit #(
    parameter logic [31:0] ADDR_MAX = 32'd63
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] ram_Address,
    output logic [31:0] ram_writeData,
    output logic        ram_Read,
    output logic        ram_Write,
    input  logic [31:0] ram_dataOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [31:0] wbuf_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] ram_address_q;
    logic        ram_read_q;
    logic        ram_write_q;

    logic [32:0] req_bytes_s;
    logic [32:0] req_end_s;
    logic        align_err_s;
    logic        range_err_s;
    logic        req_err_s;

    // Select the addressed big-endian lane of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        if (off[1]) begin
            h = word[15:0];
        end else begin
            h = word[31:16];
        end
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of a RAM word with right-justified store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] off, input logic [1:0] size);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r[31:24] = wd[7:0];
                    2'd1:    r[23:16] = wd[7:0];
                    2'd2:    r[15:8]  = wd[7:0];
                    default: r[7:0]   = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[15:0] = wd[15:0];
                end else begin
                    r[31:16] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Classify the incoming request: alignment, illegal size and RAM range.
    always_comb begin
        req_bytes_s = 33'd4;
        align_err_s = 1'b0;
        case (req_size)
            2'b00: begin
                req_bytes_s = 33'd1;
                align_err_s = 1'b0;
            end
            2'b01: begin
                req_bytes_s = 33'd2;
                align_err_s = req_addr[0];
            end
            2'b10: begin
                req_bytes_s = 33'd4;
                align_err_s = (req_addr[1:0] != 2'b00);
            end
            default: begin
                req_bytes_s = 33'd1;
                align_err_s = 1'b1;
            end
        endcase
        req_end_s   = {1'b0, req_addr} + req_bytes_s - 33'd1;
        range_err_s = (req_end_s > {1'b0, ADDR_MAX});
        req_err_s   = align_err_s | range_err_s;
    end

    // Control FSM with all outputs registered; async reset drops every RAM pin at once.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            addr_q        <= 32'h0000_0000;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= 32'h0000_0000;
            wbuf_q        <= 32'h0000_0000;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_rdata_q  <= 32'h0000_0000;
            ram_address_q <= 32'h0000_0000;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        signed_q    <= req_signed;
                        write_q     <= req_write;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_err_s) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                        end else if (req_write && (req_size == 2'b10)) begin
                            state_q       <= WRITE;
                            ram_write_q   <= 1'b1;
                            ram_address_q <= {req_addr[31:2], 2'b00};
                            wbuf_q        <= req_wdata;
                        end else begin
                            state_q       <= READ;
                            ram_read_q    <= 1'b1;
                            ram_address_q <= {req_addr[31:2], 2'b00};
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    ram_read_q <= 1'b0;
                    if (write_q) begin
                        state_q       <= WRITE;
                        ram_write_q   <= 1'b1;
                        ram_address_q <= {addr_q[31:2], 2'b00};
                        wbuf_q        <= store_merge(ram_dataOut, wdata_q, addr_q[1:0], size_q);
                    end else begin
                        state_q       <= RESP;
                        ram_address_q <= 32'h0000_0000;
                        resp_valid_q  <= 1'b1;
                        resp_error_q  <= 1'b0;
                        resp_rdata_q  <= load_extract(ram_dataOut, addr_q[1:0], size_q, signed_q);
                    end
                end
                WRITE: begin
                    state_q       <= RESP;
                    ram_write_q   <= 1'b0;
                    ram_address_q <= 32'h0000_0000;
                    wbuf_q        <= 32'h0000_0000;
                    resp_valid_q  <= 1'b1;
                    resp_error_q  <= 1'b0;
                    resp_rdata_q  <= 32'h0000_0000;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q       <= IDLE;
                    req_ready_q   <= 1'b1;
                    resp_valid_q  <= 1'b0;
                    ram_read_q    <= 1'b0;
                    ram_write_q   <= 1'b0;
                    ram_address_q <= 32'h0000_0000;
                    wbuf_q        <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_error    = resp_error_q;
    assign resp_rdata    = resp_rdata_q;
    assign ram_Address   = ram_address_q;
    assign ram_writeData = wbuf_q;
    assign ram_Read      = ram_read_q;
    assign ram_Write     = ram_write_q;

endmodule
